ringbuffer_fifo: RTL

- Parametrised successor to the sniffer's capture ring buffer; stores DW-bit LPC capture records between the decoder (writer) and the UART/readout side (reader).
- Uses the full 2^AW depth, reports exact fill level and a programmable almost-full warning, and supports drop-newest or overwrite-oldest on full.
- Keeps a sticky overflow flag with a saturating loss counter so the host can tell that records were lost.
- Storage is an internal register array; this block does not depend on an external memory module.

---
 rtl/ringbuffer_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/ringbuffer_fifo.sv
// Capture-record ring buffer between the LPC decoder (writer) and the readout side (reader).
// Full 2^AW depth, exact fill level, almost-full warning, drop-newest or overwrite-oldest on full.
module ringbuffer_fifo #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 48,
  parameter int unsigned ALMOST_FULL = 252,
  parameter int unsigned OVERWRITE   = 0,
  parameter int unsigned CW          = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          write_clock_enable,
  input  logic [DW-1:0] write_data,
  input  logic          read_clock_enable,
  output logic [DW-1:0] read_data,
  output logic          read_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [CW-1:0] drop_count,
  input  logic          clear_overflow
);

  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic rd_accept;
  logic wr_accept;
  logic wr_evict;
  logic wr_lost;

  // Pointer difference modulo 2^(AW+1) gives the exact level, 0..2^AW.
  assign level       = wr_ptr - rd_ptr;
  assign empty       = (level == '0);
  assign full        = (level == PW'(DEPTH));
  assign almost_full = (level >= PW'(ALMOST_FULL));

  // A read frees a slot on the same edge, so a write into a full FIFO with a read is never lost.
  assign rd_accept = read_clock_enable && !empty;
  assign wr_lost   = write_clock_enable && full && !rd_accept;
  assign wr_evict  = wr_lost && (OVERWRITE != 0);
  assign wr_accept = write_clock_enable && (!full || rd_accept || (OVERWRITE != 0));

  // Storage is deliberately left out of reset.
  always_ff @(negedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr[AW-1:0]] <= write_data;
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      read_valid <= rd_accept;
      if (rd_accept) begin
        read_data <= mem[rd_ptr[AW-1:0]];
      end
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      // Eviction advances rd_ptr past the slot being overwritten, so no read can tear it.
      if (rd_accept || wr_evict) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // A loss on the clearing edge wins and restarts the count at one.
      if (wr_lost) begin
        overflow <= 1'b1;
        if (clear_overflow) begin
          drop_count <= CW'(1);
        end else if (drop_count != {CW{1'b1}}) begin
          drop_count <= drop_count + CW'(1);
        end
      end else if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

endmodule
